// File: rtl/oram_cmd_responder_pkg.sv
// Shared ORAM front-end constants: command encodings, block geometry defaults
// and the responder state encoding.
package oram_cmd_responder_pkg;

  localparam int ORAM_FEDWidth      = 64;
  localparam int ORAM_FEORAMBChunks = 8;
  localparam int ORAM_BECMDWidth    = 2;

  localparam logic [1:0] BECMD_Update  = 2'd0;
  localparam logic [1:0] BECMD_Append  = 2'd1;
  localparam logic [1:0] BECMD_Read    = 2'd2;
  localparam logic [1:0] BECMD_ReadRmv = 2'd3;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    WrData  = 2'd1,
    RdFetch = 2'd2,
    RdData  = 2'd3
  } resp_state_e;

endpackage

// File: rtl/oram_cmd_responder_block_ram.sv
// Single-port block RAM with a registered read port; the read register only
// updates on a read access, so its output holds between reads.
module oram_block_ram #(
  parameter int DataWidth = 64,
  parameter int Depth     = 2048,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 Clock,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge Clock) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/oram_cmd_responder.sv
// Backend stand-in for the ORAM: accepts block commands and streams whole
// blocks of chunks in (Update/Append) or out (Read/ReadRmv) of local storage.
module oram_cmd_responder
  import oram_cmd_responder_pkg::*;
#(
  parameter int FEDWidth      = ORAM_FEDWidth,
  parameter int ORAMU         = 32,
  parameter int BECMDWidth    = ORAM_BECMDWidth,
  parameter int FEORAMBChunks = ORAM_FEORAMBChunks,
  parameter int NumBlocks     = 256
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [BECMDWidth-1:0] CmdORAM,
  input  logic [ORAMU-1:0]      PAddrORAM,
  input  logic                  CmdValidORAM,
  output logic                  CmdReadyORAM,
  input  logic [FEDWidth-1:0]   DataInORAM,
  input  logic                  DataInValidORAM,
  output logic                  DataInReadyORAM,
  output logic [FEDWidth-1:0]   DataOutORAM,
  output logic                  DataOutValidORAM,
  input  logic                  DataOutReadyORAM,
  output logic                  Busy
);

  localparam int BlkW   = $clog2(NumBlocks);
  localparam int ChunkW = $clog2(FEORAMBChunks);
  localparam int Depth  = NumBlocks * FEORAMBChunks;

  localparam logic [BECMDWidth-1:0] CmdRead    = BECMDWidth'(BECMD_Read);
  localparam logic [BECMDWidth-1:0] CmdReadRmv = BECMDWidth'(BECMD_ReadRmv);
  localparam logic [ChunkW-1:0]     LastChunk  = ChunkW'(FEORAMBChunks - 1);

  resp_state_e           state_q, state_d;
  logic [ChunkW-1:0]     chunk_q, chunk_d;
  logic [BlkW-1:0]       blk_q, blk_d;
  logic [BECMDWidth-1:0] cmd_q, cmd_d;
  logic [NumBlocks-1:0]  valid_q, valid_d;
  logic                  out_of_reset_q;

  logic                  ram_en;
  logic                  ram_we;
  logic [FEDWidth-1:0]   ram_rdata;
  logic                  cmd_is_read;
  logic                  last_chunk;

  // Only the low BlkW address bits select a block; the rest wrap silently.
  logic unused_paddr_hi;
  assign unused_paddr_hi = ^PAddrORAM[ORAMU-1:BlkW];

  assign cmd_is_read = (CmdORAM == CmdRead) || (CmdORAM == CmdReadRmv);
  assign last_chunk  = (chunk_q == LastChunk);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= Idle;
      chunk_q        <= '0;
      blk_q          <= '0;
      cmd_q          <= '0;
      valid_q        <= '0;
      out_of_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      chunk_q        <= chunk_d;
      blk_q          <= blk_d;
      cmd_q          <= cmd_d;
      valid_q        <= valid_d;
      out_of_reset_q <= 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    chunk_d          = chunk_q;
    blk_d            = blk_q;
    cmd_d            = cmd_q;
    valid_d          = valid_q;
    ram_en           = 1'b0;
    ram_we           = 1'b0;
    CmdReadyORAM     = 1'b0;
    DataInReadyORAM  = 1'b0;
    DataOutValidORAM = 1'b0;

    case (state_q)
      Idle: begin
        // Held low for the first cycle after reset so no command slips in
        // while reset is still being released.
        CmdReadyORAM = out_of_reset_q;
        if (CmdValidORAM && out_of_reset_q) begin
          cmd_d   = CmdORAM;
          blk_d   = PAddrORAM[BlkW-1:0];
          state_d = cmd_is_read ? RdFetch : WrData;
        end
      end

      WrData: begin
        DataInReadyORAM = 1'b1;
        if (DataInValidORAM) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
          if (last_chunk) begin
            valid_d[blk_q] = 1'b1;
            chunk_d        = '0;
            state_d        = Idle;
          end else begin
            chunk_d = chunk_q + ChunkW'(1);
          end
        end
      end

      RdFetch: begin
        ram_en  = 1'b1;
        state_d = RdData;
      end

      RdData: begin
        DataOutValidORAM = 1'b1;
        if (DataOutReadyORAM) begin
          if (last_chunk) begin
            chunk_d = '0;
            state_d = Idle;
            if (cmd_q == CmdReadRmv) begin
              valid_d[blk_q] = 1'b0;
            end
          end else begin
            chunk_d = chunk_q + ChunkW'(1);
            state_d = RdFetch;
          end
        end
      end

      default: state_d = Idle;
    endcase
  end

  // Unwritten or removed blocks read back as zeros, whatever the RAM holds.
  assign DataOutORAM = (DataOutValidORAM && valid_q[blk_q]) ? ram_rdata : '0;
  assign Busy        = (state_q != Idle);

  oram_block_ram #(
    .DataWidth(FEDWidth),
    .Depth    (Depth),
    .AddrWidth(BlkW + ChunkW)
  ) u_block_ram (
    .Clock  (Clock),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i ({blk_q, chunk_q}),
    .wdata_i(DataInORAM),
    .rdata_o(ram_rdata)
  );

endmodule

// File: doc/oram_cmd_responder.md
ORAM_CMD_RESPONDER -- requirements
Module: oram_cmd_responder

Interface
REQ-001 SHALL have parameters: FEDWidth, default 64, chunk width; ORAMU, default 32, program address width; BECMDWidth, default 2, command width; FEORAMBChunks, default 8, chunks per block; NumBlocks, default 256, a power of two giving the number of stored blocks.
REQ-002 SHALL have ports:
- Clock  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- CmdORAM  in  BECMDWidth  command.
- PAddrORAM  in  ORAMU  block address.
- CmdValidORAM  in  1  command valid.
- CmdReadyORAM  out  1  command accept.
- DataInORAM  in  FEDWidth  write chunk.
- DataInValidORAM  in  1  write chunk valid.
- DataInReadyORAM  out  1  write chunk accept.
- DataOutORAM  out  FEDWidth  read chunk.
- DataOutValidORAM  out  1  read chunk valid.
- DataOutReadyORAM  in  1  read chunk accept.
- Busy  out  1  high whenever the state is not Idle.

Function
REQ-003 SHALL decode commands BECMD_Update=0, BECMD_Append=1, BECMD_Read=2, BECMD_ReadRmv=3.
REQ-004 SHALL use FSM states Idle, WrData, RdFetch, RdData.
REQ-005 In Idle, SHALL drive CmdReadyORAM=1; a command is accepted on any cycle with CmdValidORAM&&CmdReadyORAM.
REQ-006 On acceptance, SHALL latch the command and Blk = PAddrORAM[log2(NumBlocks)-1:0], so upper address bits wrap silently.
REQ-007 On acceptance, SHALL go to WrData for Update/Append, or to RdFetch for Read/ReadRmv.
REQ-008 In WrData, SHALL drive DataInReadyORAM=1; each DataInValidORAM&&DataInReadyORAM cycle writes the chunk to mem[Blk][ChunkCtr] and increments ChunkCtr.
REQ-009 In WrData, the transfer with ChunkCtr==FEORAMBChunks-1 SHALL set Valid[Blk]=1, clear ChunkCtr, and return to Idle. Update and Append behave identically; Update to an invalid block also sets Valid.
REQ-010 RdFetch SHALL last exactly one cycle to issue the synchronous memory read of chunk ChunkCtr; the next cycle enters RdData with DataOutValidORAM=1. First read data therefore appears 2 cycles after command acceptance.
REQ-011 DataOutORAM SHALL equal the stored chunk when Valid[Blk]=1, else all zeros.
REQ-012 DataOutORAM and DataOutValidORAM SHALL remain stable while DataOutValidORAM&&!DataOutReadyORAM.
REQ-013 Each accepted read chunk SHALL advance ChunkCtr and return to RdFetch; back-to-back chunks are therefore spaced at least 2 cycles apart.
REQ-014 After the last chunk is accepted, SHALL clear ChunkCtr and return to Idle; for ReadRmv it SHALL also clear Valid[Blk] in that same cycle.
REQ-015 CmdReadyORAM SHALL be 0 outside Idle; a command valid during a block transfer waits.
REQ-016 DataInReadyORAM SHALL be 0 outside WrData; DataOutValidORAM SHALL be 0 outside RdData.
REQ-017 If a chunk is written during an Update of the same block, a later read returns the new data; there are no partial-block semantics beyond chunk overwrite.

Reset
REQ-018 When Reset is asserted, SHALL set the state to Idle, ChunkCtr=0, all Valid bits=0, DataOutValidORAM=0, DataInReadyORAM=0, CmdReadyORAM=0 (rising to 1 the cycle after Reset deasserts), Busy=0, and DataOutORAM=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer; a partially written block stays invalid. Memory contents need not be cleared.

Structure
REQ-020 BECMD_* encodings and the FEORAMBChunks/FEDWidth defaults SHALL live in the shared ORAM constants package used by the front end.
REQ-021 Storage SHALL be a sub-module oram_block_ram: single-port, synchronous read, depth NumBlocks*FEORAMBChunks, addressed {Blk,ChunkCtr}. Valid bits are held in flops in the top module.

Verification
REQ-022 Append at addr 0 with chunks 5,0,0…, then Read at addr 0 -> DataOut chunk0=5, the others 0, first valid 2 cycles after acceptance.
REQ-023 Read at never-written addr 7 -> FEORAMBChunks all-zero chunks; Busy falls after the last chunk is accepted.
REQ-024 Append addr 3 = 9, ReadRmv addr 3 (returns 9), then Read addr 3 -> returns 0.
REQ-025 Read with DataOutReadyORAM held low 5 cycles -> DataOut stable and valid throughout; no chunk skipped.
REQ-026 Append addr 256+2 = 11 (NumBlocks=256), then Read addr 2 -> returns 11.
REQ-027 Reset after 3 chunks of an Append to addr 4 -> Idle next cycle; a subsequent Read addr 4 returns zeros; CmdValidORAM held during WrData is not accepted until Idle.
